parametros_hacia_rtc: RTL and testbench

//  Write-side counterpart of the RTC parameter capture path. On a start pulse it latches nine

---
 rtl/parametros_hacia_rtc_pkg.sv | 35 +++
 rtl/parametros_hacia_rtc_bcd_rango_chk.sv | 15 +
 rtl/parametros_hacia_rtc.sv | 166 ++++++++++++++++
 tb/tb_parametros_hacia_rtc.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parametros_hacia_rtc_pkg.sv
// rtl/parametros_hacia_rtc_pkg.sv - shared RTC address map, BCD limits and FSM encoding
package parametros_hacia_rtc_pkg;

  // RTC register addresses (shared with the capture path)
  localparam logic [7:0] ADDR_SEG       = 8'h21;
  localparam logic [7:0] ADDR_MIN       = 8'h22;
  localparam logic [7:0] ADDR_HORA      = 8'h23;
  localparam logic [7:0] ADDR_DIA       = 8'h24;
  localparam logic [7:0] ADDR_MES       = 8'h25;
  localparam logic [7:0] ADDR_ANIO      = 8'h26;
  localparam logic [7:0] ADDR_TMR_SEG   = 8'h41;
  localparam logic [7:0] ADDR_TMR_MIN   = 8'h42;
  localparam logic [7:0] ADDR_TMR_HORA  = 8'h43;
  localparam logic [7:0] ADDR_COMMIT    = 8'hF1;
  localparam logic [7:0] DATA_COMMIT    = 8'hF2;

  localparam int NUM_FIELDS = 9;
  localparam logic [3:0] LAST_INDEX = 4'd9;

  // Snapshot of the nine fields; element 0 = seconds ... element 8 = timer hours
  typedef logic [NUM_FIELDS-1:0][7:0] params_t;

  // BCD range limits in the same field order as params_t
  localparam params_t LIM_MIN = {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
  localparam params_t LIM_MAX = {8'h23, 8'h59, 8'h59, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_GAP,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/parametros_hacia_rtc_bcd_rango_chk.sv
// rtl/parametros_hacia_rtc_bcd_rango_chk.sv - combinational BCD digit and range check
module bcd_rango_chk (
  input  logic [7:0] value,
  input  logic [7:0] min,
  input  logic [7:0] max,
  output logic       ok
);

  logic digits_ok;

  // Valid BCD digits keep the byte monotonic, so plain compares give the range test
  assign digits_ok = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9);
  assign ok = digits_ok && (value >= min) && (value <= max);

endmodule

// File: rtl/parametros_hacia_rtc.sv
// rtl/parametros_hacia_rtc.sv - latches, range-checks and writes RTC parameters over req/ack
module parametros_hacia_rtc
  import parametros_hacia_rtc_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 255,
  parameter logic [7:0] COMMIT_ADDR = ADDR_COMMIT,
  parameter logic [7:0] COMMIT_DATA = DATA_COMMIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] s_w,
  input  logic [7:0] m_w,
  input  logic [7:0] h_w,
  input  logic [7:0] d_w,
  input  logic [7:0] me_w,
  input  logic [7:0] a_w,
  input  logic [7:0] st_w,
  input  logic [7:0] mt_w,
  input  logic [7:0] ht_w,
  output logic       wr_req,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_ack,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t     state, state_n;
  logic [3:0] idx, idx_n;
  logic [7:0] cnt, cnt_n;
  params_t    snap, snap_n;
  logic       wr_req_n, busy_n, done_n, err_n;
  logic [7:0] addr_n, data_n;
  logic [NUM_FIELDS-1:0] ok_vec;
  logic       all_ok;

  // One range checker per latched field
  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_chk
    bcd_rango_chk u_chk (
      .value (snap[i]),
      .min   (LIM_MIN[i]),
      .max   (LIM_MAX[i]),
      .ok    (ok_vec[i])
    );
  end

  assign all_ok = &ok_vec;

  // Next-state and next-output logic; outputs are registered from these values
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    snap_n   = snap;
    wr_req_n = 1'b0;
    busy_n   = busy;
    done_n   = 1'b0;
    err_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          snap_n  = {ht_w, mt_w, st_w, a_w, me_w, d_w, h_w, m_w, s_w};
          busy_n  = 1'b1;
          state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (all_ok) begin
          idx_n    = 4'd0;
          cnt_n    = 8'd0;
          wr_req_n = 1'b1;
          state_n  = ST_REQ;
        end else begin
          err_n   = 1'b1;
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (wr_ack) begin
          cnt_n   = 8'd0;
          state_n = ST_GAP;
        end else if (cnt == TO_LAST) begin
          cnt_n   = 8'd0;
          idx_n   = 4'd0;
          err_n   = 1'b1;
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end else begin
          cnt_n    = cnt + 8'd1;
          wr_req_n = 1'b1;
        end
      end
      ST_GAP: begin
        // The idle cycle between writes keeps a held-high ack from counting twice
        if (idx == LAST_INDEX) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = ST_FINISH;
        end else begin
          idx_n    = idx + 4'd1;
          wr_req_n = 1'b1;
          state_n  = ST_REQ;
        end
      end
      ST_FINISH: begin
        idx_n   = 4'd0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Ten-entry address/data mux on the index the next request will carry
  always_comb begin
    addr_n = 8'h00;
    data_n = 8'h00;
    if (wr_req_n) begin
      case (idx_n)
        4'd0: begin addr_n = ADDR_SEG;      data_n = snap[0]; end
        4'd1: begin addr_n = ADDR_MIN;      data_n = snap[1]; end
        4'd2: begin addr_n = ADDR_HORA;     data_n = snap[2]; end
        4'd3: begin addr_n = ADDR_DIA;      data_n = snap[3]; end
        4'd4: begin addr_n = ADDR_MES;      data_n = snap[4]; end
        4'd5: begin addr_n = ADDR_ANIO;     data_n = snap[5]; end
        4'd6: begin addr_n = ADDR_TMR_SEG;  data_n = snap[6]; end
        4'd7: begin addr_n = ADDR_TMR_MIN;  data_n = snap[7]; end
        4'd8: begin addr_n = ADDR_TMR_HORA; data_n = snap[8]; end
        4'd9: begin addr_n = COMMIT_ADDR;   data_n = COMMIT_DATA; end
        default: begin addr_n = 8'h00;      data_n = 8'h00; end
      endcase
    end
  end

  // State, snapshot and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= 4'd0;
      cnt     <= 8'd0;
      snap    <= '0;
      wr_req  <= 1'b0;
      wr_addr <= 8'h00;
      wr_data <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      snap    <= snap_n;
      wr_req  <= wr_req_n;
      wr_addr <= addr_n;
      wr_data <= data_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

endmodule

// File: tb/tb_parametros_hacia_rtc.sv
// tb/tb_parametros_hacia_rtc.sv - self-checking bench for parametros_hacia_rtc
module tb_parametros_hacia_rtc;

  localparam int TO = 255;
  localparam logic [7:0] ADDR_MAP [10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                          8'h41, 8'h42, 8'h43, 8'hF1};

  logic       clk = 1'b0;
  logic       rst, start, wr_ack;
  logic [7:0] s_w, m_w, h_w, d_w, me_w, a_w, st_w, mt_w, ht_w;
  logic       wr_req, busy, done, err;
  logic [7:0] wr_addr, wr_data;

  int n_chk  = 0;
  int n_pass = 0;
  int ack_mode = 0;
  int wr_k = 0;
  logic       prev_req = 1'b0;
  logic [7:0] held_addr, held_data;
  logic [7:0] exp_addr [10];
  logic [7:0] exp_data [10];
  logic [7:0] act_addr [10];
  logic [7:0] act_data [10];

  always #5 clk = ~clk;

  parametros_hacia_rtc #(.TIMEOUT_CYC(TO), .COMMIT_ADDR(8'hF1), .COMMIT_DATA(8'hF2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_w(s_w), .m_w(m_w), .h_w(h_w), .d_w(d_w), .me_w(me_w), .a_w(a_w),
    .st_w(st_w), .mt_w(mt_w), .ht_w(ht_w),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: the ten writes that must appear, straight from the current field values
  task automatic load_model();
    logic [7:0] vals [9];
    vals = '{s_w, m_w, h_w, d_w, me_w, a_w, st_w, mt_w, ht_w};
    for (int i = 0; i < 10; i++) begin
      exp_addr[i] = ADDR_MAP[i];
      exp_data[i] = (i < 9) ? vals[i] : 8'hF2;
    end
  endtask

  task automatic set_valid();
    s_w = 8'h45; m_w = 8'h30; h_w = 8'h12; d_w = 8'h15; me_w = 8'h06;
    a_w = 8'h16; st_w = 8'h10; mt_w = 8'h05; ht_w = 8'h01;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int c = 0;
    while (!done && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", done, 1);
  endtask

  // Bus driver stand-in: never acks, acks on the 3rd request cycle, or holds ack high
  initial begin
    int age = 0;
    wr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_req) age++; else age = 0;
      case (ack_mode)
        1: wr_ack = wr_req && (age == 3);
        2: wr_ack = 1'b1;
        default: wr_ack = 1'b0;
      endcase
    end
  end

  // Per-cycle compare against the expected write list
  always @(negedge clk) begin
    if (!rst) begin
      if (done || err) chk("done_err_exclusive", done & err, 0);
      if (wr_req) begin
        chk("req_implies_busy", busy, 1);
        if (!prev_req) begin
          if (wr_k < 10) begin
            chk("wr_addr", wr_addr, exp_addr[wr_k]);
            chk("wr_data", wr_data, exp_data[wr_k]);
            act_addr[wr_k] = wr_addr;
            act_data[wr_k] = wr_data;
          end else begin
            chk("req_count", wr_k + 1, 10);
          end
          wr_k++;
        end else begin
          chk("addr_stable", wr_addr, held_addr);
          chk("data_stable", wr_data, held_data);
        end
        held_addr = wr_addr;
        held_data = wr_data;
      end
    end
    prev_req = wr_req;
  end

  initial begin
    int c;
    rst = 1'b1; start = 1'b0;
    s_w = 0; m_w = 0; h_w = 0; d_w = 0; me_w = 0; a_w = 0; st_w = 0; mt_w = 0; ht_w = 0;
    repeat (2) @(negedge clk);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    rst = 1'b0;

    // Valid run, ack three cycles after each request
    ack_mode = 1;
    set_valid();
    load_model();
    wr_k = 0;
    pulse_start();
    chk("lat_busy", busy, 1);
    chk("lat_req_early", wr_req, 0);
    @(negedge clk);
    chk("lat_req", wr_req, 1);
    wait_done(300);
    chk("done_busy_low", busy, 0);
    chk("valid_count", wr_k, 10);
    chk("pin_addr0", act_addr[0], 8'h21);
    chk("pin_data0", act_data[0], 8'h45);
    chk("pin_data2", act_data[2], 8'h12);
    chk("pin_addr6", act_addr[6], 8'h41);
    chk("pin_data8", act_data[8], 8'h01);
    chk("pin_addr9", act_addr[9], 8'hF1);
    chk("pin_data9", act_data[9], 8'hF2);
    @(negedge clk);
    chk("done_one_cycle", done, 0);

    // Invalid BCD cases
    for (int k = 0; k < 3; k++) begin
      set_valid();
      case (k)
        0: m_w = 8'h60;
        1: m_w = 8'h1A;
        default: d_w = 8'h00;
      endcase
      wr_k = 0;
      pulse_start();
      chk("bad_err_early", err, 0);
      @(negedge clk);
      chk("bad_err", err, 1);
      chk("bad_busy", busy, 0);
      @(negedge clk);
      chk("bad_err_pulse", err, 0);
      repeat (3) @(negedge clk);
      chk("bad_no_req", wr_k, 0);
    end

    // Ack timeout
    ack_mode = 0;
    set_valid();
    load_model();
    wr_k = 0;
    pulse_start();
    @(negedge clk);
    chk("to_req", wr_req, 1);
    c = 0;
    while (!err && c < TO + 20) begin
      @(negedge clk);
      c++;
    end
    chk("to_cycles", c, TO);
    chk("to_busy", busy, 0);
    chk("to_req_low", wr_req, 0);
    chk("to_one_req", wr_k, 1);
    ack_mode = 1;
    wr_k = 0;
    pulse_start();
    wait_done(300);
    chk("after_to_count", wr_k, 10);

    // Ack held high; start and input changes mid-run are ignored
    ack_mode = 2;
    set_valid();
    load_model();
    wr_k = 0;
    pulse_start();
    @(negedge clk);
    chk("hold_req", wr_req, 1);
    c = 0;
    while (!done && c < 60) begin
      start = (c == 6);
      if (c == 6) s_w = 8'h00;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk("hold_cycles", c, 20);
    repeat (5) @(negedge clk);
    chk("hold_busy", busy, 0);
    chk("hold_count", wr_k, 10);

    // Reset during write index 4, then restart
    ack_mode = 1;
    set_valid();
    load_model();
    wr_k = 0;
    pulse_start();
    c = 0;
    while (!(wr_req && wr_addr == 8'h25) && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("mid_reached", wr_addr, 8'h25);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_wr_req", wr_req, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_err", err, 0);
    chk("mid_wr_addr", wr_addr, 0);
    chk("mid_wr_data", wr_data, 0);
    rst = 1'b0;
    wr_k = 0;
    pulse_start();
    @(negedge clk);
    chk("restart_addr", wr_addr, 8'h21);
    wait_done(300);
    chk("restart_count", wr_k, 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
